// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot and auto-reload modes.
// Drives a registered interrupt request toward CP0 hwint[2].
module timer_counter #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    addr,
    input  logic          we,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          irq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } state_t;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;
    localparam logic [DW-1:0] ONE   = DW'(1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_ctrl;
    logic [3:0]    w_ctrl_nxt;
    logic [DW-1:0] r_preset;
    logic [DW-1:0] w_preset_nxt;
    logic [DW-1:0] r_count;
    logic [DW-1:0] w_count_nxt;
    logic          r_irq_flag;
    logic          w_flag_nxt;

    logic w_ctrl_wr;
    logic w_preset_wr;
    logic w_en;
    logic w_auto;
    logic w_zero;

    assign w_ctrl_wr   = we && (addr == A_CTRL);
    assign w_preset_wr = we && (addr == A_PRESET);
    assign w_en        = r_ctrl[0];
    assign w_auto      = (r_ctrl[2:1] == 2'b01);
    assign w_zero      = (r_count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl     <= '0;
            r_preset   <= '0;
            r_count    <= '0;
            r_irq_flag <= 1'b0;
        end else begin
            r_ctrl     <= w_ctrl_nxt;
            r_preset   <= w_preset_nxt;
            r_count    <= w_count_nxt;
            r_irq_flag <= w_flag_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ctrl_nxt   = r_ctrl;
        w_preset_nxt = r_preset;
        w_count_nxt  = r_count;
        w_flag_nxt   = r_irq_flag;

        unique case (r_state)
            S_IDLE: begin
                if (w_en) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_count_nxt = r_preset;
                w_state_nxt = S_CNT;
            end
            S_CNT: begin
                if (!w_en) begin
                    w_state_nxt = S_IDLE;
                end else if (!w_zero) begin
                    w_count_nxt = r_count - ONE;
                end else begin
                    w_flag_nxt  = 1'b1;
                    w_state_nxt = S_INT;
                end
            end
            S_INT: begin
                if (w_auto) begin
                    w_flag_nxt  = 1'b0;
                    w_state_nxt = S_LOAD;
                end else begin
                    w_ctrl_nxt[0] = 1'b0;
                    w_state_nxt   = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Bus writes override whatever the FSM did to CTRL and the flag.
        if (w_preset_wr) begin
            w_preset_nxt = din;
        end
        if (w_ctrl_wr) begin
            w_ctrl_nxt = din[3:0];
            w_flag_nxt = 1'b0;
        end
    end

    always_comb begin
        dout = '0;
        unique case (addr)
            A_CTRL:   dout = {{(DW-4){1'b0}}, r_ctrl};
            A_PRESET: dout = r_preset;
            A_COUNT:  dout = r_count;
            default:  dout = '0;
        endcase
    end

    assign irq = r_irq_flag & r_ctrl[3];

endmodule
